// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit positions and shifter state encoding
// for the memory-mapped UART transmitter.
package mmio_uart_pkg;

    localparam logic [3:0] OFF_STATUS = 4'h0;
    localparam logic [3:0] OFF_DATA   = 4'h4;
    localparam logic [3:0] OFF_DIV    = 4'h8;
    localparam logic [3:0] OFF_RSVD   = 4'hC;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the UART shifter. A push while full is dropped even
// when a pop happens on the same edge.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [7:0]   wdata,
    input  logic         pop,
    output logic [7:0]   rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: 16-byte register window, byte FIFO and
// an 8N1 shifter whose bit time is latched from DIV at frame start.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          DIV_RESET = 16,
    parameter logic [31:0] BASE      = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    logic        sel;
    logic [3:0]  offset;
    logic        wr_status, wr_data, wr_div;
    logic        fifo_full, fifo_empty, fifo_pop;
    logic [7:0]  fifo_rdata;
    logic [AW:0] fifo_count;

    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;

    tx_state_e   state_q;
    logic        tx_q;
    logic [15:0] timer_q, div_lat_q;
    logic [7:0]  shift_q;
    logic [2:0]  bitcnt_q;

    logic        unused_bits;
    assign unused_bits = ^{addr[1:0], WriteData[31:16]};

    assign sel       = (addr[31:4] == BASE[31:4]);
    assign offset    = {addr[3:2], 2'b00};
    assign wr_status = MemWrite && sel && (offset == OFF_STATUS);
    assign wr_data   = MemWrite && sel && (offset == OFF_DATA);
    assign wr_div    = MemWrite && sel && (offset == OFF_DIV);

    // The shifter drains the FIFO head on the edge it leaves IDLE.
    assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

    tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .wdata (WriteData[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_div)
            div_d = (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
        if (wr_data && fifo_full)
            ovf_d = 1'b1;
        else if (wr_status)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= 16'(DIV_RESET);
            ovf_q <= 1'b0;
        end else begin
            div_q <= div_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            timer_q   <= '0;
            div_lat_q <= '0;
            shift_q   <= '0;
            bitcnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q   <= fifo_rdata;
                        timer_q   <= div_q;
                        div_lat_q <= div_q;
                        state_q   <= S_START;
                        tx_q      <= 1'b0;
                    end
                end
                S_START: begin
                    if (timer_q == 16'd1) begin
                        timer_q  <= div_lat_q;
                        bitcnt_q <= '0;
                        state_q  <= S_DATA;
                        tx_q     <= shift_q[0];
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (timer_q == 16'd1) begin
                        timer_q <= div_lat_q;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            shift_q  <= shift_q >> 1;
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (timer_q == 16'd1) begin
                        timer_q <= '0;
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE) || !fifo_empty;

    always_comb begin
        ReadData = '0;
        if (sel) begin
            case (offset)
                OFF_STATUS: begin
                    ReadData[ST_BUSY]  = busy;
                    ReadData[ST_FULL]  = fifo_full;
                    ReadData[ST_EMPTY] = fifo_empty;
                    ReadData[ST_OVF]   = ovf_q;
                    ReadData[ST_CNT_LSB +: CNT_W] = CNT_W'(fifo_count);
                end
                OFF_DIV:  ReadData[15:0] = div_q;
                default:  ReadData = '0;
            endcase
        end
    end

endmodule
